// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//
// Purpose:
//   Watches a multiplexed 4-digit 7-segment display bus and rebuilds the
//   16-bit hex value on it. The bus is active-low for both anodes and
//   segments. A digit is accepted only after its anode and segment
//   pattern have held steady for STABLE_CNT samples. A new value is
//   published once all four digits have been accepted.
//
// Parameters:
//   STABLE_CNT   identical consecutive samples needed to accept a digit (>= 2)
//   TIMEOUT      cycles without an accept before value_valid drops
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   an_in  [3:0] in   anode lines, active-low, one-hot-low digit select
//   seg_in [7:0] in   segment lines, active-low, [6:0]=g..a, [7]=dp
//   value [15:0] out  captured value, digit i -> value[4i+3:4i]
//   dp     [3:0] out  captured decimal points, active-high
//   bad_digit[3:0] out  digit had an undecodable pattern in the last frame
//   value_valid  out  value holds a complete, non-stale frame
//   update       out  one-cycle pulse when value/dp/bad_digit load
//   changed      out  one-cycle pulse with update when the value differs
//   multi_err    out  sticky, more than one anode was seen low
module seg_scan_capture #(
  parameter int STABLE_CNT = 1024,
  parameter int TIMEOUT    = 2097152
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_in,
  input  logic [7:0]  seg_in,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  bad_digit,
  output logic        value_valid,
  output logic        update,
  output logic        changed,
  output logic        multi_err
);

  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT);
  // An accept fires on the edge that moves stab_cnt to STABLE_CNT-1.
  // At that point STABLE_CNT identical samples have been seen.
  localparam logic [SW-1:0] STAB_ACC = SW'(STABLE_CNT - 2);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_HIT  = TW'(TIMEOUT - 2);

  // Synchroniser stages, plus the previous synchronised sample for stability checking
  logic [3:0]    an_s1, an_s, an_p;
  logic [7:0]    seg_s1, seg_s, seg_p;

  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    seen, seen_next;
  logic [15:0]   shadow;
  logic [3:0]    shad_dp;
  logic [3:0]    shad_bad;

  logic [1:0]    idx;
  logic          idx_valid;
  logic          multi;
  logic          same;
  logic          accept;
  logic          frame_done;
  logic          tmo_hit;
  logic [4:0]    dec;

  // Returns {bad, nibble}; bad is set and the nibble is 0 for unknown patterns
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    idx       = 2'd0;
    idx_valid = 1'b1;
    multi     = 1'b0;
    case (an_s)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      4'b1111: idx_valid = 1'b0;
      default: begin
        idx_valid = 1'b0;
        multi     = 1'b1;
      end
    endcase

    same       = ({an_s, seg_s} == {an_p, seg_p});
    accept     = idx_valid && same && (stab_cnt == STAB_ACC);
    frame_done = (seen == 4'b1111);
    tmo_hit    = !accept && (tmo_cnt == TMO_HIT);
    dec        = decode_seg(seg_s[6:0]);

    // Completion clears seen. An accept in the same cycle starts the next frame.
    seen_next = frame_done ? 4'b0000 : seen;
    if (accept)
      seen_next[idx] = 1'b1;
    if (tmo_hit)
      seen_next = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Synchroniser and history reset to the idle bus level (all lines high).
      // This keeps the first samples after reset from reading as a multi-anode glitch.
      an_s1       <= 4'hF;
      an_s        <= 4'hF;
      an_p        <= 4'hF;
      seg_s1      <= 8'hFF;
      seg_s       <= 8'hFF;
      seg_p       <= 8'hFF;
      stab_cnt    <= '0;
      tmo_cnt     <= '0;
      seen        <= 4'b0000;
      shadow      <= 16'h0000;
      shad_dp     <= 4'b0000;
      shad_bad    <= 4'b0000;
      value       <= 16'h0000;
      dp          <= 4'b0000;
      bad_digit   <= 4'b0000;
      value_valid <= 1'b0;
      update      <= 1'b0;
      changed     <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      an_s1  <= an_in;
      an_s   <= an_s1;
      seg_s1 <= seg_in;
      seg_s  <= seg_s1;
      an_p   <= an_s;
      seg_p  <= seg_s;

      if (multi || !same)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;

      if (multi)
        multi_err <= 1'b1;

      if (accept) begin
        shadow[{idx, 2'b00} +: 4] <= dec[3:0];
        shad_dp[idx]              <= ~seg_s[7];
        shad_bad[idx]             <= dec[4];
        tmo_cnt                   <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      seen <= seen_next;

      update  <= 1'b0;
      changed <= 1'b0;
      if (frame_done) begin
        value       <= shadow;
        dp          <= shad_dp;
        bad_digit   <= shad_bad;
        value_valid <= 1'b1;
        update      <= 1'b1;
        changed     <= (shadow != value) || !value_valid;
      end else if (tmo_hit) begin
        value_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture
//
// Purpose:
//   Self-checking bench for seg_scan_capture with STABLE_CNT=4 and TIMEOUT=64.
//   The stimulus tasks push the expected frames into a queue.
//   A negedge monitor pops one expected frame for each update pulse and compares it.
//
// Ports: none (top-level bench)
module tb_seg_scan_capture;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  bad;
    logic        changed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_in;
  logic [7:0]  seg_in;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  bad_digit;
  logic        value_valid;
  logic        update;
  logic        changed;
  logic        multi_err;

  int   total_checks = 0;
  int   bad_checks   = 0;
  int   cycle        = 0;
  int   update_count = 0;
  int   last_update_cycle = 0;
  exp_t exp_q[$];
  exp_t exp_cur;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  seg_scan_capture #(
    .STABLE_CNT(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .an_in(an_in),
    .seg_in(seg_in),
    .value(value),
    .dp(dp),
    .bad_digit(bad_digit),
    .value_valid(value_valid),
    .update(update),
    .changed(changed),
    .multi_err(multi_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Holds one anode/segment pattern on the bus for n clock cycles
  task automatic applyStimulus(input logic [3:0] an, input logic [7:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scanFrame(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3, input int dwell);
    applyStimulus(4'b1110, s0, dwell);
    applyStimulus(4'b1101, s1, dwell);
    applyStimulus(4'b1011, s2, dwell);
    applyStimulus(4'b0111, s3, dwell);
  endtask

  task automatic pushExp(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b, input logic c);
    exp_t e;
    e.value   = v;
    e.dp      = d;
    e.bad     = b;
    e.changed = c;
    exp_q.push_back(e);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++)
      @(posedge clk);
    checkOutput(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic checkAllZero(input string tag);
    @(negedge clk);
    checkOutput({tag, "_value"},   value,       0);
    checkOutput({tag, "_dp"},      dp,          0);
    checkOutput({tag, "_bad"},     bad_digit,   0);
    checkOutput({tag, "_valid"},   value_valid, 0);
    checkOutput({tag, "_update"},  update,      0);
    checkOutput({tag, "_changed"}, changed,     0);
    checkOutput({tag, "_multi"},   multi_err,   0);
  endtask

  // Scoreboard side: each update pulse must match the oldest pending frame
  always @(negedge clk) begin
    if (rst_n === 1'b1 && update === 1'b1) begin
      update_count++;
      last_update_cycle = cycle;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_update", 1, 0);
      end else begin
        exp_cur = exp_q.pop_front();
        checkOutput("value",       value,       exp_cur.value);
        checkOutput("dp",          dp,          exp_cur.dp);
        checkOutput("bad_digit",   bad_digit,   exp_cur.bad);
        checkOutput("changed",     changed,     exp_cur.changed);
        checkOutput("value_valid", value_valid, 1);
      end
    end
    if (changed === 1'b1 && update !== 1'b1)
      checkOutput("changed_without_update", 1, 0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int n0;

    rst_n  = 1'b0;
    an_in  = 4'hF;
    seg_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(4'hF, 8'hFF, 6);
    @(negedge clk);
    checkOutput("multi_after_reset", multi_err, 0);

    $display("[TB] test 1: basic scan");
    pushExp(16'h4321, 4'b0000, 4'b0000, 1'b1);
    scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    applyStimulus(4'hF, 8'hFF, 5);
    waitDrain("t1_drain");
    checkOutput("t1_update_count", update_count, 1);

    $display("[TB] test 2: repeat scan then change digit 3");
    pushExp(16'h4321, 4'b0000, 4'b0000, 1'b0);
    scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    pushExp(16'hF321, 4'b0000, 4'b0000, 1'b1);
    scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h8E, 10);
    applyStimulus(4'hF, 8'hFF, 5);
    waitDrain("t2_drain");
    checkOutput("t2_update_count", update_count, 3);

    $display("[TB] test 3: short dwell and timeout");
    t0 = last_update_cycle;
    n0 = update_count;
    scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 3);
    scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 3);
    an_in  = 4'hF;
    seg_in = 8'hFF;
    while (cycle < t0 + 40) @(negedge clk);
    checkOutput("t3_valid_before_timeout", value_valid, 1);
    while (cycle < t0 + 70) @(negedge clk);
    checkOutput("t3_valid_after_timeout", value_valid, 0);
    checkOutput("t3_value_held", value, 16'hF321);
    checkOutput("t3_no_update", update_count, n0);
    #1;

    $display("[TB] test 4: undecodable digit and decimal point");
    pushExp(16'h4301, 4'b0100, 4'b0010, 1'b1);
    scanFrame(8'hF9, 8'hFF, 8'h30, 8'h99, 10);
    applyStimulus(4'hF, 8'hFF, 5);
    waitDrain("t4_drain");

    $display("[TB] test 5: multi-anode glitch");
    n0 = update_count;
    applyStimulus(4'b1101, 8'hA4, 10);
    applyStimulus(4'b1011, 8'hB0, 10);
    applyStimulus(4'b0111, 8'h99, 10);
    applyStimulus(4'b1110, 8'hF9, 2);
    applyStimulus(4'b1100, 8'hF9, 1);
    applyStimulus(4'b1110, 8'hF9, 3);
    applyStimulus(4'hF, 8'hFF, 10);
    @(negedge clk);
    checkOutput("t5_multi_set", multi_err, 1);
    checkOutput("t5_dwell_restarted", update_count, n0);
    #1;
    pushExp(16'h4321, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b1110, 8'hF9, 10);
    applyStimulus(4'hF, 8'hFF, 5);
    waitDrain("t5_drain");
    @(negedge clk);
    checkOutput("t5_multi_sticky", multi_err, 1);
    #1;

    $display("[TB] test 6: reset mid-frame");
    applyStimulus(4'b1110, 8'hC0, 10);
    applyStimulus(4'b1101, 8'hF9, 10);
    an_in  = 4'hF;
    seg_in = 8'hFF;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("t6_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = update_count;
    applyStimulus(4'hF, 8'hFF, 4);
    pushExp(16'h3254, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b1011, 8'hA4, 10);
    applyStimulus(4'b0111, 8'hB0, 10);
    applyStimulus(4'b1110, 8'h99, 10);
    applyStimulus(4'b1101, 8'h92, 10);
    applyStimulus(4'hF, 8'hFF, 5);
    waitDrain("t6_drain");
    checkOutput("t6_single_update", update_count, n0 + 1);
    @(negedge clk);
    checkOutput("t6_multi_cleared", multi_err, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
